// File: rtl/data_memory_dumper_if.sv
// Bundle of the dumper's handshake signals: start/busy/done control,
// the data memory read port and the UART TX byte handshake.
interface data_memory_dumper_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] addr_data;
    logic [DATA_W-1:0] mem_data;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done_tick;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_data, tx_done_tick,
        output addr_data, tx_data, tx_start, busy, done
    );

    modport slave (
        output start, mem_data, tx_done_tick,
        input  addr_data, tx_data, tx_start, busy, done
    );
endinterface

// File: rtl/data_memory_dumper.sv
// Debug-unit read master: walks data memory from address 0 to N_WORDS-1 and
// streams every 16-bit word to the UART TX as two bytes, high byte first.
//
// state   | meaning
// IDLE    | waiting for a sampled start request
// READ    | address presented, waiting out the memory read latency
// LATCH   | capture the memory word, launch the high byte
// WAIT_HI | high byte in flight; done tick launches the low byte
// WAIT_LO | low byte in flight; done tick advances the address or finishes
// DONE    | pulse done, drop busy, park the address back at 0
module data_memory_dumper #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 16,
    parameter int N_WORDS = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_dumper_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        LATCH   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Termination is an equality compare, so a full 2^ADDR_W dump never wraps.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State and all registered outputs; every output is driven straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state decode; done ticks only matter while a byte is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_q) state_d = READ;
            READ:    state_d = LATCH;
            LATCH:   state_d = WAIT_HI;
            WAIT_HI: if (bus.tx_done_tick) state_d = WAIT_LO;
            WAIT_LO: if (bus.tx_done_tick) state_d = (addr_q == LAST_ADDR) ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the output/datapath registers for each state.
    always_comb begin
        start_d    = 1'b0;
        addr_d     = addr_q;
        word_d     = word_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // start is captured only here, so requests during a dump are dropped
                if (start_q) begin
                    addr_d = '0;
                    busy_d = 1'b1;
                end else begin
                    start_d = bus.start;
                end
            end
            LATCH: begin
                word_d     = bus.mem_data;
                tx_data_d  = bus.mem_data[DATA_W-1 -: 8];
                tx_start_d = 1'b1;
            end
            WAIT_HI: begin
                if (bus.tx_done_tick) begin
                    tx_data_d  = word_q[7:0];
                    tx_start_d = 1'b1;
                end
            end
            WAIT_LO: begin
                if (bus.tx_done_tick && (addr_q != LAST_ADDR)) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                addr_d = '0;
            end
            default: begin
                busy_d = busy_q;
            end
        endcase
    end

    assign bus.addr_data = addr_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_data_memory_dumper.sv
// Bench for data_memory_dumper: four instances with different dump lengths,
// each with its own memory, TX responder and a behavioural model that
// predicts the byte stream and handshake timing cycle by cycle.
module tb_data_memory_dumper;
    localparam int NCFG = 4;
    localparam int INF  = 32'h3fff_ffff;

    function automatic int cfg_words(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 33;
            default: return 2048;
        endcase
    endfunction

    logic clk;
    logic reset;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    logic start_drv [NCFG];
    logic spur      [NCFG];

    wire [31:0] done_cnt_w [NCFG];
    wire [31:0] ts_cnt_w   [NCFG];
    wire [31:0] byte_idx_w [NCFG];
    wire        waiting_w  [NCFG];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used as the model's time base.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int inst, input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL i%0d %s: got %0h, expected %0h (t=%0t)", inst, name, got, exp, $time);
        end
    endtask

    for (genvar k = 0; k < NCFG; k++) begin : g_inst
        localparam int N = cfg_words(k);

        data_memory_dumper_if #(.ADDR_W(11), .DATA_W(16)) ifc ();

        data_memory_dumper #(
            .ADDR_W (11),
            .DATA_W (16),
            .N_WORDS(N)
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (ifc.master)
        );

        logic [15:0] mem [0:2047];
        logic [15:0] mem_q   = 16'h0;
        logic        ack_drv = 1'b0;
        logic        s_start = 1'b0;
        logic        s_ack   = 1'b0;

        int   x;
        int   byte_idx      = 0;
        int   busy_from     = INF;
        int   busy_until    = INF;
        int   next_ts       = -1;
        int   done_edge     = -1;
        int   idle_after    = 0;
        int   ack_cnt       = 0;
        int   ts_cnt        = 0;
        int   done_cnt      = 0;
        int   start_edge    = 0;
        int   first_ts_edge = 0;
        int   addr_exp;
        bit   running       = 0;
        bit   waiting       = 0;
        bit   tx_busy       = 0;
        logic [7:0]  cur_byte = 8'h0;
        logic [7:0]  obs     [$];
        logic [10:0] ts_addr [$];

        assign ifc.start        = start_drv[k];
        assign ifc.mem_data     = mem_q;
        assign ifc.tx_done_tick = ack_drv;
        assign done_cnt_w[k]    = done_cnt;
        assign ts_cnt_w[k]      = ts_cnt;
        assign byte_idx_w[k]    = byte_idx;
        assign waiting_w[k]     = waiting;

        // Memory image: random fill plus the words the scenarios pin down.
        initial begin
            for (int a = 0; a < 2048; a++) mem[a] = 16'($urandom);
            if (k == 0) begin
                mem[0] = 16'h0001;
                mem[1] = 16'h000F;
            end
            if (k == 1) mem[0] = 16'hA55A;
            if (k == 2) mem[32] = 16'h0014;
        end

        // Synchronous-read memory; returns garbage while a byte is in flight
        // so a dumper that re-reads mem_data after latching is exposed.
        always @(posedge clk) mem_q <= tx_busy ? 16'($urandom) : mem[ifc.addr_data];

        // Inputs as the DUT sees them at each rising edge.
        always @(posedge clk) begin
            s_start <= ifc.start;
            s_ack   <= ifc.tx_done_tick;
        end

        // Outputs must clear as soon as reset is raised, without a clock.
        always @(posedge reset) begin
            #1;
            if (cyc > 2) begin
                chk(k, "async_rst_addr", 32'(ifc.addr_data), 0);
                chk(k, "async_rst_tx_start", 32'(ifc.tx_start), 0);
                chk(k, "async_rst_busy", 32'(ifc.busy), 0);
                chk(k, "async_rst_done", 32'(ifc.done), 0);
                chk(k, "async_rst_tx_data", 32'(ifc.tx_data), 0);
            end
        end

        // Model update, output comparison and TX responder, once per cycle.
        always @(negedge clk) begin
            x = cyc;
            if (reset) begin
                running    = 0;
                waiting    = 0;
                byte_idx   = 0;
                busy_from  = INF;
                busy_until = INF;
                next_ts    = -1;
                done_edge  = -1;
                idle_after = x;
                chk(k, "rst_addr", 32'(ifc.addr_data), 0);
                chk(k, "rst_tx_data", 32'(ifc.tx_data), 0);
                chk(k, "rst_tx_start", 32'(ifc.tx_start), 0);
                chk(k, "rst_busy", 32'(ifc.busy), 0);
                chk(k, "rst_done", 32'(ifc.done), 0);
            end else begin
                if (s_start && !running && x > idle_after) begin
                    running    = 1;
                    busy_from  = x + 1;
                    busy_until = INF;
                    next_ts    = x + 3;
                    byte_idx   = 0;
                    start_edge = x;
                    ts_cnt     = 0;
                    obs.delete();
                    ts_addr.delete();
                end
                if (s_ack && waiting) begin
                    waiting  = 0;
                    byte_idx = byte_idx + 1;
                    if (byte_idx == 2 * N) begin
                        done_edge  = x + 1;
                        busy_until = x + 1;
                        idle_after = x + 1;
                        running    = 0;
                    end else if (byte_idx % 2 == 1) begin
                        next_ts = x;
                    end else begin
                        next_ts = x + 2;
                    end
                end
                if (x >= busy_from && x < busy_until)
                    addr_exp = (byte_idx / 2 < N) ? byte_idx / 2 : N - 1;
                else
                    addr_exp = 0;
                chk(k, "addr_data", 32'(ifc.addr_data), 32'(addr_exp));
                chk(k, "busy", 32'(ifc.busy), 32'(x >= busy_from && x < busy_until));
                chk(k, "done", 32'(ifc.done), 32'(x == done_edge));
                chk(k, "tx_start", 32'(ifc.tx_start), 32'(x == next_ts));
                if (ifc.done) done_cnt++;
                if (ifc.tx_start) begin
                    ts_cnt++;
                    obs.push_back(ifc.tx_data);
                    ts_addr.push_back(ifc.addr_data);
                    if (x == next_ts) begin
                        cur_byte = (byte_idx % 2 == 1) ? mem[byte_idx / 2][7:0] : mem[byte_idx / 2][15:8];
                        chk(k, "tx_data", 32'(ifc.tx_data), 32'(cur_byte));
                        if (byte_idx == 0) first_ts_edge = x;
                        waiting = 1;
                        next_ts = -1;
                    end
                end else if (waiting) begin
                    chk(k, "tx_data_hold", 32'(ifc.tx_data), 32'(cur_byte));
                end
            end

            // TX responder: keeps running through DUT reset, like a real UART.
            if (ifc.tx_start && !reset) begin
                tx_busy = 1;
                if (k == 0)      ack_cnt = 10;
                else if (k == 3) ack_cnt = 1;
                else             ack_cnt = int'($urandom_range(1, 6));
            end
            ack_drv = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    ack_drv = 1'b1;
                    tx_busy = 0;
                end
            end else if (spur[k] && !tx_busy) begin
                ack_drv = 1'b1;
            end
        end
    end

    task automatic pulse(input int k);
        start_drv[k] = 1'b1;
        @(negedge clk);
        start_drv[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, input string name);
        logic [31:0] d0;
        bit seen;
        d0   = done_cnt_w[k];
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt_w[k] != d0) seen = 1;
        end
        chk(k, name, 32'(seen), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        for (int i = 0; i < NCFG; i++) begin
            start_drv[i] = 1'b0;
            spur[i]      = 1'b0;
        end
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        // N=2: interrupt in WAIT_LO at address 1, then a clean dump.
        pulse(0);
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (byte_idx_w[0] == 3 && waiting_w[0]) hit = 1;
        end
        chk(0, "reach_wait_lo_addr1", 32'(hit), 1);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (15) @(negedge clk);
        pulse(0);
        wait_done(0, 400, "n2_done_seen");
        chk(0, "n2_nbytes", 32'(g_inst[0].obs.size()), 4);
        chk(0, "n2_byte0", 32'(g_inst[0].obs[0]), 32'h00);
        chk(0, "n2_byte1", 32'(g_inst[0].obs[1]), 32'h01);
        chk(0, "n2_byte2", 32'(g_inst[0].obs[2]), 32'h00);
        chk(0, "n2_byte3", 32'(g_inst[0].obs[3]), 32'h0F);
        chk(0, "n2_addr_b0", 32'(g_inst[0].ts_addr[0]), 0);
        chk(0, "n2_addr_b2", 32'(g_inst[0].ts_addr[2]), 1);
        chk(0, "n2_addr_after", 32'(g_inst[0].ifc.addr_data), 0);
        chk(0, "n2_done_pulses", done_cnt_w[0], 1);

        // N=1: single word, first tx_start three edges after start.
        pulse(1);
        wait_done(1, 200, "n1_done_seen");
        chk(1, "n1_nbytes", 32'(g_inst[1].obs.size()), 2);
        chk(1, "n1_byte0", 32'(g_inst[1].obs[0]), 32'hA5);
        chk(1, "n1_byte1", 32'(g_inst[1].obs[1]), 32'h5A);
        chk(1, "n1_first_ts_latency", 32'(g_inst[1].first_ts_edge - g_inst[1].start_edge), 3);

        // N=33 with spurious done ticks and a mid-dump start re-pulse.
        spur[2] = 1'b1;
        repeat (4) @(negedge clk);
        pulse(2);
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (ts_cnt_w[2] >= 10) hit = 1;
        end
        chk(2, "n33_mid_dump", 32'(hit), 1);
        pulse(2);
        wait_done(2, 2000, "n33_done_seen");
        spur[2] = 1'b0;
        chk(2, "n33_ts_count", ts_cnt_w[2], 66);
        chk(2, "n33_byte64", 32'(g_inst[2].obs[64]), 32'h00);
        chk(2, "n33_byte65", 32'(g_inst[2].obs[65]), 32'h14);
        chk(2, "n33_done_pulses", done_cnt_w[2], 1);

        // N=2048 full address space with a fast TX.
        pulse(3);
        wait_done(3, 12000, "n2048_done_seen");
        chk(3, "n2048_nbytes", 32'(g_inst[3].obs.size()), 4096);
        chk(3, "n2048_last_addr", 32'(g_inst[3].ts_addr[4095]), 2047);
        chk(3, "n2048_first_addr", 32'(g_inst[3].ts_addr[0]), 0);

        // Reset while idle.
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
